tcb_lite_lib_register_response: RTL and testbench
=================================================

Name: tcb_lite_lib_register_response

Overview:
- Register slice for the TCB-Lite response path; companion to the request-path register slice.
- Passes the request and handshake through combinationally and registers the manager-side response, so the subordinate-side response delay is DLY_MAN+1.
- A transfer-tracking pipeline loads the response register only when a response is actually due (power optimisation).

Parameters:
- DAT, 32, data width in bits (multiple of 8).
- ADR, 32, address width.
- BYT, DAT/8, number of byte lanes.
- STS, 1, status width.
- MOD, 1'b1, request byte encoding: 0 = logarithmic size `siz`, 1 = byte enable `byt`.
- DLY_MAN, 0, response delay of the downstream (manager-side) device, 0..7.
- OPT, "POWER", "POWER" = gated loads; "COMPLEXITY" = load every cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- sub_vld  in  1  request valid from upstream manager.
- sub_rdy  out  1  ready to upstream.
- sub_req  in  REQ_W  packed request {lck,ndn,wen,adr,siz|byt,wdt,ctl}.
- sub_rsp_rdt  out  DAT  registered read data.
- sub_rsp_sts  out  STS  registered status.
- sub_rsp_err  out  1  registered error.
- man_vld  out  1  request valid to downstream.
- man_rdy  in  1  ready from downstream.
- man_req  out  REQ_W  request to downstream.
- man_rsp_rdt  in  DAT  read data, valid DLY_MAN cycles after a transfer.
- man_rsp_sts  in  STS  status from downstream.
- man_rsp_err  in  1  error from downstream.

Behaviour:
- Pass-through, combinational, no state:
  - man_vld = sub_vld.
  - man_req = sub_req.
  - sub_rdy = man_rdy.
  - trn = sub_vld & man_rdy.
- Tracker stage 0 (combinational) = {trn, wen, lane mask}.
  - Lane mask bit i: MOD=1 → byt[i]; MOD=0 → (i < 2**siz).
- Tracker stages 1..DLY_MAN are registers shifted every cycle.
- Tracker stage DLY_MAN is the "due" entry. When DLY_MAN=0, due = stage 0.
- Load rules for OPT="POWER":
  - due.vld=1: load sub_rsp_sts and sub_rsp_err from the manager side.
  - due.vld=1 and due.wen=0: load byte lane i of sub_rsp_rdt only if mask[i]=1.
  - Any other case: hold all outputs.
- Load rule for OPT="COMPLEXITY": load all three response fields every cycle. The tracker is not instantiated.
- Latency: a response is visible on sub_rsp_* exactly DLY_MAN+1 cycles after the sub-side transfer cycle.
- Throughput: back-to-back transfers (one per cycle) each produce their own response in consecutive cycles; no bubbles inserted.
- Reset (rst=1 at a clock edge):
  - All tracker stages cleared.
  - sub_rsp_rdt, sub_rsp_sts and sub_rsp_err set to 0.
  - Pass-through paths are unaffected.
- Reset mid-operation: in-flight tracked transfers are discarded. Their responses are never loaded and outputs stay 0 until the next due entry.
- Write transfers: sts and err are updated; rdt holds its previous value (POWER).
- Reads with a partial mask: disabled lanes hold their previous value (POWER).
- Simultaneous reset and due entry: reset wins.
- Elaboration checks:
  - DAT % 8 == 0.
  - 0 <= DLY_MAN <= 7.
  - OPT is one of the two legal strings.
  - An illegal value raises an error.

Decomposition:
- tcb_lite_pkg holds:
  - packed request typedef and REQ_W;
  - response typedef {rdt,sts,err};
  - tracker entry typedef {vld, wen, msk[BYT]};
  - a function converting siz to a lane mask.
- One sub-module: tcb_lite_lib_response_tracker.
  - Parameterised shift register of tracker entries with depth DLY_MAN.
  - Synchronous clear on rst.
  - Outputs the due entry.

Test Plan:
- DLY_MAN=0, MOD=1: read with byt=4'b1111, man_rsp_rdt=32'hDEADBEEF → sub_rsp_rdt=32'hDEADBEEF one cycle later; sts=0, err=0.
- DLY_MAN=2: reads back-to-back to 0x0, 0x4, 0x8 returning 0x11111111, 0x22222222, 0x33333333 → sub_rsp_rdt shows them on cycles T+3, T+4, T+5.
- Preload rdt=32'hAAAAAAAA, then read with byt=4'b0011 and man rdt=32'h12345678 → 32'hAAAA5678. Then a write with man_rsp_err=1 → err=1, rdt unchanged.
- MOD=0, read with siz=1 → only lanes 0-1 updated; with siz=2 → all lanes updated.
- DLY_MAN=2: two reads in flight, assert rst for one cycle → outputs 0, no response loaded at T+3/T+4; the next read after reset is delivered normally.
- OPT="COMPLEXITY": sub_rsp_rdt follows man_rsp_rdt with one cycle delay regardless of transfers; pass-through paths stay exact (man_vld=sub_vld, sub_rdy=man_rdy) while man_rdy toggles.

Source files
------------

// File: rtl/tcb_lite_pkg.sv
// Shared TCB-Lite types and helpers for the response-path register slice.
// The typedefs describe the default 32-bit configuration; parameterised blocks derive their own widths.
package tcb_lite_pkg;

    localparam int unsigned SIZ_W = 3;  // logarithmic size field, up to 128-byte transfers
    localparam int unsigned CTL_W = 1;

    typedef struct packed {
        logic             lck;
        logic             ndn;
        logic             wen;
        logic [31:0]      adr;
        logic [3:0]       byt;
        logic [31:0]      wdt;
        logic [CTL_W-1:0] ctl;
    } tcb_lite_req_t;

    localparam int unsigned REQ_W = $bits(tcb_lite_req_t);

    typedef struct packed {
        logic [31:0] rdt;
        logic [0:0]  sts;
        logic        err;
    } tcb_lite_rsp_t;

    typedef struct packed {
        logic       vld;
        logic       wen;
        logic [3:0] msk;
    } tcb_lite_trk_t;

    function automatic int unsigned req_width(input int unsigned adr, input int unsigned dat,
                                              input int unsigned ben);
        return 3 + adr + ben + dat + CTL_W;
    endfunction

    // One lane of the siz-to-mask conversion: lane is enabled when it lies inside 2**siz bytes.
    function automatic logic siz_lane_en(input logic [SIZ_W-1:0] siz, input int unsigned lane);
        return lane < (32'd1 << siz);
    endfunction

endpackage

// File: rtl/tcb_lite_lib_response_tracker.sv
// Shift register of tracker entries; the last stage is the entry whose response is due now.
// Only instantiated for a non-zero delay, the zero-delay case is a wire in the parent.
module tcb_lite_lib_response_tracker #(
    parameter int unsigned W   = 6,
    parameter int unsigned DLY = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] stg0_i,
    output logic [W-1:0] due_o
);

    logic [W-1:0] stg_q [1:DLY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= DLY; i++) begin
                stg_q[i] <= '0;
            end
        end else begin
            stg_q[1] <= stg0_i;
            for (int i = 2; i <= DLY; i++) begin
                stg_q[i] <= stg_q[i-1];
            end
        end
    end

    assign due_o = stg_q[DLY];

endmodule

// File: rtl/tcb_lite_lib_register_response.sv
// TCB-Lite response register slice: request/handshake pass straight through, the response is
// registered, and in POWER mode the register only loads the lanes of a response that is due.
module tcb_lite_lib_register_response
    import tcb_lite_pkg::*;
#(
    parameter int unsigned DAT     = 32,
    parameter int unsigned ADR     = 32,
    parameter int unsigned BYT     = DAT/8,
    parameter int unsigned STS     = 1,
    parameter bit          MOD     = 1'b1,
    parameter int unsigned DLY_MAN = 0,
    parameter string       OPT     = "POWER",
    localparam int unsigned BEN_W  = MOD ? BYT : SIZ_W,
    localparam int unsigned RQ_W   = req_width(ADR, DAT, BEN_W)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sub_vld,
    output logic            sub_rdy,
    input  logic [RQ_W-1:0] sub_req,
    output logic [DAT-1:0]  sub_rsp_rdt,
    output logic [STS-1:0]  sub_rsp_sts,
    output logic            sub_rsp_err,
    output logic            man_vld,
    input  logic            man_rdy,
    output logic [RQ_W-1:0] man_req,
    input  logic [DAT-1:0]  man_rsp_rdt,
    input  logic [STS-1:0]  man_rsp_sts,
    input  logic            man_rsp_err
);

    if (DAT % 8 != 0) begin : g_err_dat
        $error("DAT must be a multiple of 8");
    end
    if (DLY_MAN > 7) begin : g_err_dly
        $error("DLY_MAN must be in 0..7");
    end
    if (OPT != "POWER" && OPT != "COMPLEXITY") begin : g_err_opt
        $error("OPT must be POWER or COMPLEXITY");
    end

    typedef struct packed {
        logic           vld;
        logic           wen;
        logic [BYT-1:0] msk;
    } trk_t;

    assign man_vld = sub_vld;
    assign man_req = sub_req;
    assign sub_rdy = man_rdy;

    logic [DAT-1:0] rdt_q, rdt_d;
    logic [STS-1:0] sts_q, sts_d;
    logic           err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdt_q <= '0;
            sts_q <= '0;
            err_q <= 1'b0;
        end else begin
            rdt_q <= rdt_d;
            sts_q <= sts_d;
            err_q <= err_d;
        end
    end

    assign sub_rsp_rdt = rdt_q;
    assign sub_rsp_sts = sts_q;
    assign sub_rsp_err = err_q;

    if (OPT == "POWER") begin : g_power
        logic [BEN_W-1:0] ben;
        logic [BYT-1:0]   msk;
        trk_t             stg0;
        trk_t             due;

        // Request layout {lck,ndn,wen,adr,ben,wdt,ctl}, MSB first.
        assign ben = sub_req[CTL_W+DAT +: BEN_W];

        if (MOD) begin : g_byt
            assign msk = ben;
        end else begin : g_siz
            for (genvar i = 0; i < BYT; i++) begin : g_lane
                assign msk[i] = siz_lane_en(ben, i);
            end
        end

        assign stg0.vld = sub_vld & man_rdy;
        assign stg0.wen = sub_req[RQ_W-3];
        assign stg0.msk = msk;

        if (DLY_MAN == 0) begin : g_nodly
            assign due = stg0;
        end else begin : g_dly
            tcb_lite_lib_response_tracker #(
                .W   ($bits(trk_t)),
                .DLY (DLY_MAN)
            ) u_trk (
                .clk    (clk),
                .rst    (rst),
                .stg0_i (stg0),
                .due_o  (due)
            );
        end

        always_comb begin
            rdt_d = rdt_q;
            sts_d = sts_q;
            err_d = err_q;
            if (due.vld) begin
                sts_d = man_rsp_sts;
                err_d = man_rsp_err;
                if (!due.wen) begin
                    for (int i = 0; i < BYT; i++) begin
                        if (due.msk[i]) rdt_d[8*i +: 8] = man_rsp_rdt[8*i +: 8];
                    end
                end
            end
        end
    end else begin : g_complexity
        always_comb begin
            rdt_d = man_rsp_rdt;
            sts_d = man_rsp_sts;
            err_d = man_rsp_err;
        end
    end

endmodule

// File: tb/tb_tcb_lite_lib_register_response.sv
// Bench for the TCB-Lite response register slice: four configurations share one stimulus
// stream and are compared each cycle against a history-based model of when responses are due.
module tb_tcb_lite_lib_register_response;

  localparam int RW1 = 72;  // request width, byte-enable encoding
  localparam int RW0 = 71;  // request width, logarithmic size encoding

  logic clk;
  logic rst;
  logic sub_vld, man_rdy, wen, ctl;
  logic [3:0]  byt;
  logic [2:0]  siz;
  logic [31:0] adr, wdt;
  logic [31:0] man_rdt;
  logic        man_sts, man_err;
  logic [RW1-1:0] req1;
  logic [RW0-1:0] req0;

  assign req1 = {1'b0, 1'b0, wen, adr, byt, wdt, ctl};
  assign req0 = {1'b0, 1'b0, wen, adr, siz, wdt, ctl};

  logic           rdy_d0, rdy_d2, rdy_m0, rdy_cx;
  logic           vld_d0, vld_d2, vld_m0, vld_cx;
  logic [RW1-1:0] req_d0, req_d2, req_cx;
  logic [RW0-1:0] req_m0;
  logic [31:0]    rdt_d0, rdt_d2, rdt_m0, rdt_cx;
  logic           sts_d0, sts_d2, sts_m0, sts_cx;
  logic           err_d0, err_d2, err_m0, err_cx;

  tcb_lite_lib_register_response #(.MOD(1'b1), .DLY_MAN(0), .OPT("POWER")) u_d0 (
    .clk(clk), .rst(rst), .sub_vld(sub_vld), .sub_rdy(rdy_d0), .sub_req(req1),
    .sub_rsp_rdt(rdt_d0), .sub_rsp_sts(sts_d0), .sub_rsp_err(err_d0),
    .man_vld(vld_d0), .man_rdy(man_rdy), .man_req(req_d0),
    .man_rsp_rdt(man_rdt), .man_rsp_sts(man_sts), .man_rsp_err(man_err));

  tcb_lite_lib_register_response #(.MOD(1'b1), .DLY_MAN(2), .OPT("POWER")) u_d2 (
    .clk(clk), .rst(rst), .sub_vld(sub_vld), .sub_rdy(rdy_d2), .sub_req(req1),
    .sub_rsp_rdt(rdt_d2), .sub_rsp_sts(sts_d2), .sub_rsp_err(err_d2),
    .man_vld(vld_d2), .man_rdy(man_rdy), .man_req(req_d2),
    .man_rsp_rdt(man_rdt), .man_rsp_sts(man_sts), .man_rsp_err(man_err));

  tcb_lite_lib_register_response #(.MOD(1'b0), .DLY_MAN(1), .OPT("POWER")) u_m0 (
    .clk(clk), .rst(rst), .sub_vld(sub_vld), .sub_rdy(rdy_m0), .sub_req(req0),
    .sub_rsp_rdt(rdt_m0), .sub_rsp_sts(sts_m0), .sub_rsp_err(err_m0),
    .man_vld(vld_m0), .man_rdy(man_rdy), .man_req(req_m0),
    .man_rsp_rdt(man_rdt), .man_rsp_sts(man_sts), .man_rsp_err(man_err));

  tcb_lite_lib_register_response #(.MOD(1'b1), .DLY_MAN(0), .OPT("COMPLEXITY")) u_cx (
    .clk(clk), .rst(rst), .sub_vld(sub_vld), .sub_rdy(rdy_cx), .sub_req(req1),
    .sub_rsp_rdt(rdt_cx), .sub_rsp_sts(sts_cx), .sub_rsp_err(err_cx),
    .man_vld(vld_cx), .man_rdy(man_rdy), .man_req(req_cx),
    .man_rsp_rdt(man_rdt), .man_rsp_sts(man_sts), .man_rsp_err(man_err));

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: per-edge history (index 0 = latest edge) of reset and transfers.
  // A response at edge k comes from the transfer at edge k-DLY, provided no reset hit
  // any edge in between (inclusive of both ends).
  logic       h_rst [8];
  logic       h_trn [8];
  logic       h_wen [8];
  logic [3:0] h_m1  [8];
  logic [3:0] h_m0  [8];

  int         dly_of [3] = '{0, 2, 1};
  bit         mod_of [3] = '{1'b1, 1'b1, 1'b0};
  logic [31:0] e_rdt [3];
  logic        e_sts [3];
  logic        e_err [3];
  logic [31:0] e_rdt_cx;
  logic        e_sts_cx, e_err_cx;

  function automatic logic [3:0] siz_mask(input logic [2:0] s);
    logic [3:0] m;
    int lanes;
    lanes = 1 << s;
    m = 4'b0;
    for (int i = 0; i < 4; i++) if (i < lanes) m[i] = 1'b1;
    return m;
  endfunction

  task automatic model_edge();
    for (int i = 7; i > 0; i--) begin
      h_rst[i] = h_rst[i-1];
      h_trn[i] = h_trn[i-1];
      h_wen[i] = h_wen[i-1];
      h_m1[i]  = h_m1[i-1];
      h_m0[i]  = h_m0[i-1];
    end
    h_rst[0] = rst;
    h_trn[0] = sub_vld & man_rdy;
    h_wen[0] = wen;
    h_m1[0]  = byt;
    h_m0[0]  = siz_mask(siz);
    for (int n = 0; n < 3; n++) begin
      int d;
      logic due;
      logic [3:0] m;
      d = dly_of[n];
      due = h_trn[d];
      for (int j = 0; j <= d; j++) if (h_rst[j]) due = 1'b0;
      m = mod_of[n] ? h_m1[d] : h_m0[d];
      if (rst) begin
        e_rdt[n] = '0;
        e_sts[n] = 1'b0;
        e_err[n] = 1'b0;
      end else if (due) begin
        e_sts[n] = man_sts;
        e_err[n] = man_err;
        if (!h_wen[d]) begin
          for (int l = 0; l < 4; l++) if (m[l]) e_rdt[n][8*l +: 8] = man_rdt[8*l +: 8];
        end
      end
    end
    e_rdt_cx = rst ? 32'h0 : man_rdt;
    e_sts_cx = rst ? 1'b0 : man_sts;
    e_err_cx = rst ? 1'b0 : man_err;
  endtask

  task automatic compare_all();
    check("d0_rdt", rdt_d0, e_rdt[0]);
    check("d0_sts", sts_d0, e_sts[0]);
    check("d0_err", err_d0, e_err[0]);
    check("d2_rdt", rdt_d2, e_rdt[1]);
    check("d2_sts", sts_d2, e_sts[1]);
    check("d2_err", err_d2, e_err[1]);
    check("m0_rdt", rdt_m0, e_rdt[2]);
    check("m0_sts", sts_m0, e_sts[2]);
    check("m0_err", err_m0, e_err[2]);
    check("cx_rdt", rdt_cx, e_rdt_cx);
    check("cx_sts", sts_cx, e_sts_cx);
    check("cx_err", err_cx, e_err_cx);
  endtask

  // driver task: one clock cycle of stimulus, pass-through checks, then model and outputs
  task automatic step(input logic r, input logic v, input logic rd, input logic w,
                      input logic [3:0] b, input logic [2:0] s, input logic [31:0] md,
                      input logic ms, input logic me);
    rst = r; sub_vld = v; man_rdy = rd; wen = w; byt = b; siz = s;
    adr = $urandom; wdt = $urandom; ctl = 1'($urandom_range(0, 1));
    man_rdt = md; man_sts = ms; man_err = me;
    #1;
    check("pt_vld", {vld_d0, vld_d2, vld_m0, vld_cx}, {4{v}});
    check("pt_rdy", {rdy_d0, rdy_d2, rdy_m0, rdy_cx}, {4{rd}});
    check("pt_req_d0", req_d0, {1'b0, 1'b0, w, adr, b, wdt, ctl});
    check("pt_req_d2", req_d2, {1'b0, 1'b0, w, adr, b, wdt, ctl});
    check("pt_req_m0", req_m0, {1'b0, 1'b0, w, adr, s, wdt, ctl});
    check("pt_req_cx", req_cx, {1'b0, 1'b0, w, adr, b, wdt, ctl});
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      h_rst[i] = 1'b0; h_trn[i] = 1'b0; h_wen[i] = 1'b0; h_m1[i] = 4'h0; h_m0[i] = 4'h0;
    end
    for (int n = 0; n < 3; n++) begin
      e_rdt[n] = '0; e_sts[n] = 1'b0; e_err[n] = 1'b0;
    end
    e_rdt_cx = '0; e_sts_cx = 1'b0; e_err_cx = 1'b0;
    rst = 1'b1; sub_vld = 1'b0; man_rdy = 1'b0; wen = 1'b0; byt = '0; siz = '0;
    adr = '0; wdt = '0; ctl = 1'b0; man_rdt = 32'hFFFF_FFFF; man_sts = 1'b1; man_err = 1'b1;
    @(posedge clk);
    #1;

    // reset: outputs cleared even with a response pending on the manager side
    step(1, 1, 1, 0, 4'hF, 3'd2, 32'h9999_9999, 1, 1);
    step(1, 0, 1, 0, 4'hF, 3'd2, 32'h9999_9999, 1, 1);
    check("rst_rdt_d0", rdt_d0, 32'h0);
    check("rst_rdt_cx", rdt_cx, 32'h0);
    check("rst_err_d2", err_d2, 1'b0);

    // zero-delay full read
    step(0, 1, 1, 0, 4'hF, 3'd2, 32'hDEAD_BEEF, 0, 0);
    check("d0_read_full", rdt_d0, 32'hDEAD_BEEF);
    check("d0_read_sts", sts_d0, 1'b0);
    check("d0_read_err", err_d0, 1'b0);

    // delay-2 back-to-back reads
    step(0, 1, 1, 0, 4'hF, 3'd2, 32'h0, 0, 0);
    step(0, 1, 1, 0, 4'hF, 3'd2, 32'h0, 0, 0);
    step(0, 1, 1, 0, 4'hF, 3'd2, 32'h1111_1111, 0, 0);
    check("d2_b2b_0", rdt_d2, 32'h1111_1111);
    step(0, 0, 1, 0, 4'hF, 3'd2, 32'h2222_2222, 0, 0);
    check("d2_b2b_1", rdt_d2, 32'h2222_2222);
    step(0, 0, 1, 0, 4'hF, 3'd2, 32'h3333_3333, 0, 0);
    check("d2_b2b_2", rdt_d2, 32'h3333_3333);

    // partial byte-enable read, then a write carrying an error
    step(0, 1, 1, 0, 4'hF, 3'd2, 32'hAAAA_AAAA, 0, 0);
    step(0, 1, 1, 0, 4'h3, 3'd2, 32'h1234_5678, 0, 0);
    check("d0_partial", rdt_d0, 32'hAAAA_5678);
    step(0, 1, 1, 1, 4'hF, 3'd2, 32'h0BAD_0BAD, 0, 1);
    check("d0_wr_err", err_d0, 1'b1);
    check("d0_wr_rdt", rdt_d0, 32'hAAAA_5678);

    // logarithmic size: siz=1 touches lanes 0-1, siz=2 all lanes
    step(0, 1, 1, 0, 4'hF, 3'd2, 32'h0, 0, 0);
    step(0, 0, 1, 0, 4'hF, 3'd2, 32'hFFFF_FFFF, 0, 0);
    step(0, 1, 1, 0, 4'hF, 3'd1, 32'h0, 0, 0);
    step(0, 0, 1, 0, 4'hF, 3'd1, 32'h1234_5678, 0, 0);
    check("m0_siz1", rdt_m0, 32'hFFFF_5678);
    step(0, 1, 1, 0, 4'hF, 3'd2, 32'h0, 0, 0);
    step(0, 0, 1, 0, 4'hF, 3'd2, 32'hCAFE_F00D, 0, 0);
    check("m0_siz2", rdt_m0, 32'hCAFE_F00D);

    // reset with two reads in flight on the delay-2 instance
    step(0, 1, 1, 0, 4'hF, 3'd2, 32'h0, 0, 0);
    step(0, 1, 1, 0, 4'hF, 3'd2, 32'h0, 0, 0);
    step(1, 0, 1, 0, 4'hF, 3'd2, 32'h5555_5555, 0, 0);
    check("d2_rst_0", rdt_d2, 32'h0);
    step(0, 0, 1, 0, 4'hF, 3'd2, 32'h5555_5555, 1, 1);
    check("d2_rst_1", rdt_d2, 32'h0);
    step(0, 0, 1, 0, 4'hF, 3'd2, 32'h5555_5555, 1, 1);
    check("d2_rst_2", rdt_d2, 32'h0);
    check("d2_rst_err", err_d2, 1'b0);
    step(0, 1, 1, 0, 4'hF, 3'd2, 32'h0, 0, 0);
    step(0, 0, 1, 0, 4'hF, 3'd2, 32'h0, 0, 0);
    step(0, 0, 1, 0, 4'hF, 3'd2, 32'h6666_6666, 0, 0);
    check("d2_after_rst", rdt_d2, 32'h6666_6666);

    // complexity mode follows the manager side without a transfer
    step(0, 0, 0, 0, 4'h0, 3'd0, 32'h1357_9BDF, 1, 0);
    check("cx_follow", rdt_cx, 32'h1357_9BDF);

    // randomized traffic with toggling ready and occasional reset
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 4'($urandom), 3'($urandom_range(0, 3)), $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
